fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_arb_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   DEF_DW      : default data width, matching the 8-bit async FIFO
//   STALL_W     : width of the blocked-write statistics counter
//   STALL_MAX   : saturation value of the statistics counter
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int                 DEF_DW    = 8;
    localparam int                 STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_arb_rr_pick
// Combinational round-robin picker: returns the first set bit of req found by
// scanning upward from ptr and wrapping modulo NREQ.
//   req   in  NREQ : request vector
//   ptr   in  IW   : scan start index (must be < NREQ)
//   found out 1    : at least one request is set
//   idx   out IW   : index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module fifo_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [IW:0] w_pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(NREQ)) begin
                w_pos = w_pos - (IW+1)'(NREQ);
            end
            if (!found && req[w_pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the write side of the async FIFO among NREQ
// requesters, in the FIFO write-clock domain. A grant is held for at most
// BURST accepted writes, then rotates. No write is issued while full is high.
//
// Optional build macro: FIFO_WR_ARB_STATS_EN enables the blocked-write
// counter on stall_cnt; without it stall_cnt is tied to zero.
//
// Ports:
//   wrclk     in  1        write-side clock
//   rst       in  1        synchronous active-high reset
//   req       in  NREQ     per-requester write request
//   req_data  in  NREQ*DW  packed requester words, requester i at [i*DW +: DW]
//   ack       out NREQ     one-hot: requester's current word written this cycle
//   full      in  1        FIFO full flag (registered inside the FIFO)
//   wr        out 1        FIFO write enable
//   data      out DW       FIFO write data
//   busy      out 1        a grant is held
//   stall_cnt out 16       saturating count of blocked-write cycles
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = DEF_DW,
    parameter int BURST = 4
) (
    input  logic                 wrclk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    input  logic                 full,
    output logic                 wr,
    output logic [DW-1:0]        data,
    output logic                 busy,
    output logic [STALL_W-1:0]   stall_cnt
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST) + 1;

    arb_state_t    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gidx;
    logic [BW-1:0] r_bcnt;

    logic          w_grant;
    logic          w_req_g;
    logic          w_wr;
    logic          w_last;
    logic          w_release;
    logic [IW-1:0] w_pick_ptr;
    logic          w_found;
    logic [IW-1:0] w_pick;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(NREQ - 1)) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    assign w_grant   = (r_state == GRANT);
    assign w_req_g   = req[r_gidx];
    assign w_wr      = w_grant & w_req_g & ~full;
    assign w_last    = (r_bcnt == BW'(BURST - 1));
    assign w_release = w_grant & (~w_req_g | (w_wr & w_last));

    // While granted, the picker always looks one past the current holder so
    // a release can re-arbitrate on the same edge with no bubble; the holder
    // itself is reached last, so it only wins again if nobody else waits.
    assign w_pick_ptr = w_grant ? wrap_inc(r_gidx) : r_ptr;

    fifo_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    always_comb begin
        wr   = w_wr;
        busy = w_grant;
        ack  = '0;
        if (w_wr) begin
            ack[r_gidx] = 1'b1;
        end
        data = w_grant ? req_data[int'(r_gidx)*DW +: DW] : '0;
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_gidx  <= w_pick;
                        r_bcnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr  <= w_pick_ptr;
                        r_bcnt <= '0;
                        if (w_found) begin
                            r_gidx <= w_pick;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_wr) begin
                        r_bcnt <= r_bcnt + BW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STALL_W-1:0] r_stall;

    // A blocked cycle is one where the holder wants to write but full stops it.
    always_ff @(posedge wrclk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_grant && w_req_g && full && (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule
